mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port synchronous data memory between the CPU load/store path (RD/WR) and the stack unit (psh/pop).
- Sits between the control-unit-driven datapath and the data RAM.
- Serialises accesses with a req/gnt/done handshake.
- Drives registered memory strobes.
- Returns read data per requester.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
// The arbiter takes the slave view; requesters and memory sit on the master side.
interface mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          done0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          done1;
  logic [DW-1:0] rdata1;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, done0, rdata0, gnt1, done1, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, done0, rdata0, gnt1, done1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous data RAM between the
// CPU load/store path (port 0) and the stack unit (port 1).
module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_r, next_state_s;

  logic          gnt0_r, gnt1_r, done0_r, done1_r, mem_en_r, mem_we_r, busy_r;
  logic          gnt0_s, gnt1_s, done0_s, done1_s, mem_en_s, mem_we_s, busy_s;
  logic [AW-1:0] mem_addr_r, mem_addr_s;
  logic [DW-1:0] mem_wdata_r, mem_wdata_s;
  logic [DW-1:0] rdata0_r, rdata0_s, rdata1_r, rdata1_s;
  logic          last_grant_r, last_grant_s;
  logic          winner_r, winner_s;
  logic          op_we_r, op_we_s;
  logic          win0_s, win1_s;

  // last_grant of 1 means port 1 was served last, so port 0 takes a tie.
  assign win0_s = bus.req0 & (~bus.req1 | last_grant_r);
  assign win1_s = bus.req1 & (~bus.req0 | ~last_grant_r);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE:    next_state_s = (win0_s | win1_s) ? ACCESS : IDLE;
      ACCESS:  next_state_s = WAIT;
      WAIT:    next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the per-access latches.
  always_comb begin
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    done0_s      = 1'b0;
    done1_s      = 1'b0;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    rdata0_s     = rdata0_r;
    rdata1_s     = rdata1_r;
    last_grant_s = last_grant_r;
    winner_s     = winner_r;
    op_we_s      = op_we_r;
    case (state_r)
      IDLE: begin
        if (win0_s) begin
          gnt0_s       = 1'b1;
          mem_en_s     = 1'b1;
          mem_we_s     = bus.we0;
          mem_addr_s   = bus.addr0;
          mem_wdata_s  = bus.wdata0;
          last_grant_s = 1'b0;
          winner_s     = 1'b0;
          op_we_s      = bus.we0;
        end else if (win1_s) begin
          gnt1_s       = 1'b1;
          mem_en_s     = 1'b1;
          mem_we_s     = bus.we1;
          mem_addr_s   = bus.addr1;
          mem_wdata_s  = bus.wdata1;
          last_grant_s = 1'b1;
          winner_s     = 1'b1;
          op_we_s      = bus.we1;
        end else begin
          winner_s     = winner_r;
        end
      end
      ACCESS: begin
        mem_en_s = 1'b0;
      end
      WAIT: begin
        // RAM output is valid here; capture it only for reads.
        if (!op_we_r && winner_r) begin
          rdata1_s = bus.mem_rdata;
        end else if (!op_we_r) begin
          rdata0_s = bus.mem_rdata;
        end else begin
          rdata0_s = rdata0_r;
        end
        if (winner_r) begin
          done1_s = 1'b1;
        end else begin
          done0_s = 1'b1;
        end
      end
      DONE: begin
        done0_s = 1'b0;
      end
      default: begin
        mem_en_s = 1'b0;
      end
    endcase
    busy_s = (next_state_s != IDLE);
  end

  // Output and latch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt0_r       <= 1'b0;
      gnt1_r       <= 1'b0;
      done0_r      <= 1'b0;
      done1_r      <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      busy_r       <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      rdata0_r     <= '0;
      rdata1_r     <= '0;
      last_grant_r <= 1'b1;
      winner_r     <= 1'b0;
      op_we_r      <= 1'b0;
    end else begin
      gnt0_r       <= gnt0_s;
      gnt1_r       <= gnt1_s;
      done0_r      <= done0_s;
      done1_r      <= done1_s;
      mem_en_r     <= mem_en_s;
      mem_we_r     <= mem_we_s;
      busy_r       <= busy_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      rdata0_r     <= rdata0_s;
      rdata1_r     <= rdata1_s;
      last_grant_r <= last_grant_s;
      winner_r     <= winner_s;
      op_we_r      <= op_we_s;
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.done0     = done0_r;
  assign bus.done1     = done1_r;
  assign bus.rdata0    = rdata0_r;
  assign bus.rdata1    = rdata1_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// reset, withdrawn-request and reset-during-access sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if #(.AW(10), .DW(16)) bus ();

  mem_arbiter #(.AW(10), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model; two locations carry fixed preload contents.
  logic [15:0] ram [0:1023];
  function automatic logic [15:0] ram_read(input logic [9:0] a);
    if (a == 10'h010) return 16'h1234;
    else if (a == 10'h3FF) return 16'hA5A5;
    else return ram[a];
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram_read(bus.mem_addr);
    end
  end

  typedef struct {
    logic        r0, w0;
    logic [9:0]  a0;
    logic [15:0] d0;
    logic        r1, w1;
    logic [9:0]  a1;
    logic [15:0] d1;
    logic [6:0]  flags;   // {gnt0,gnt1,done0,done1,mem_en,mem_we,busy}
    logic [9:0]  addr;
    logic [15:0] rd0, rd1;
  } vec_t;

  vec_t vecs [0:28];

  function automatic logic [6:0] flags_now();
    return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_en, bus.mem_we, bus.busy};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic w0, input logic [9:0] a0,
                              input logic [15:0] d0, input logic r1, input logic w1,
                              input logic [9:0] a1, input logic [6:0] f,
                              input logic [9:0] ad, input logic [15:0] rd0,
                              input logic [15:0] rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = 16'h0000;
    v.flags = f; v.addr = ad; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.req0 = v.r0; bus.we0 = v.w0; bus.addr0 = v.a0; bus.wdata0 = v.d0;
    bus.req1 = v.r1; bus.we1 = v.w1; bus.addr1 = v.a1; bus.wdata1 = v.d1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
    bus.mem_rdata = 16'h0000;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 10'h000; bus.wdata0 = 16'h0000;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 10'h000; bus.wdata1 = 16'h0000;

    // write 0x005, read back on port 1, contention 0/1/0, port 1 back-to-back
    vecs[0]  = mk(0,0,10'h000,16'h0000, 0,0,10'h000, 7'b0000000, 10'h000, 16'h0000, 16'h0000);
    vecs[1]  = mk(1,1,10'h005,16'hBEEF, 0,0,10'h000, 7'b1000111, 10'h005, 16'h0000, 16'h0000);
    vecs[2]  = mk(1,1,10'h005,16'hBEEF, 0,0,10'h000, 7'b0000001, 10'h005, 16'h0000, 16'h0000);
    vecs[3]  = mk(1,1,10'h005,16'hBEEF, 0,0,10'h000, 7'b0010001, 10'h005, 16'h0000, 16'h0000);
    vecs[4]  = mk(0,0,10'h000,16'h0000, 0,0,10'h000, 7'b0000000, 10'h005, 16'h0000, 16'h0000);
    vecs[5]  = mk(0,0,10'h000,16'h0000, 1,0,10'h005, 7'b0100101, 10'h005, 16'h0000, 16'h0000);
    vecs[6]  = mk(0,0,10'h000,16'h0000, 1,0,10'h005, 7'b0000001, 10'h005, 16'h0000, 16'h0000);
    vecs[7]  = mk(0,0,10'h000,16'h0000, 1,0,10'h005, 7'b0001001, 10'h005, 16'h0000, 16'hBEEF);
    vecs[8]  = mk(0,0,10'h000,16'h0000, 0,0,10'h000, 7'b0000000, 10'h005, 16'h0000, 16'hBEEF);
    vecs[9]  = mk(1,0,10'h010,16'h0000, 1,0,10'h3FF, 7'b1000101, 10'h010, 16'h0000, 16'hBEEF);
    vecs[10] = mk(1,0,10'h010,16'h0000, 1,0,10'h3FF, 7'b0000001, 10'h010, 16'h0000, 16'hBEEF);
    vecs[11] = mk(1,0,10'h010,16'h0000, 1,0,10'h3FF, 7'b0010001, 10'h010, 16'h1234, 16'hBEEF);
    vecs[12] = mk(1,0,10'h010,16'h0000, 1,0,10'h3FF, 7'b0000000, 10'h010, 16'h1234, 16'hBEEF);
    vecs[13] = mk(1,0,10'h010,16'h0000, 1,0,10'h3FF, 7'b0100101, 10'h3FF, 16'h1234, 16'hBEEF);
    vecs[14] = mk(1,0,10'h010,16'h0000, 1,0,10'h3FF, 7'b0000001, 10'h3FF, 16'h1234, 16'hBEEF);
    vecs[15] = mk(1,0,10'h010,16'h0000, 1,0,10'h3FF, 7'b0001001, 10'h3FF, 16'h1234, 16'hA5A5);
    vecs[16] = mk(1,0,10'h010,16'h0000, 1,0,10'h3FF, 7'b0000000, 10'h3FF, 16'h1234, 16'hA5A5);
    vecs[17] = mk(1,0,10'h010,16'h0000, 1,0,10'h3FF, 7'b1000101, 10'h010, 16'h1234, 16'hA5A5);
    vecs[18] = mk(1,0,10'h010,16'h0000, 1,0,10'h3FF, 7'b0000001, 10'h010, 16'h1234, 16'hA5A5);
    vecs[19] = mk(1,0,10'h010,16'h0000, 1,0,10'h3FF, 7'b0010001, 10'h010, 16'h1234, 16'hA5A5);
    vecs[20] = mk(0,0,10'h000,16'h0000, 1,0,10'h3FF, 7'b0000000, 10'h010, 16'h1234, 16'hA5A5);
    vecs[21] = mk(0,0,10'h000,16'h0000, 1,0,10'h3FF, 7'b0100101, 10'h3FF, 16'h1234, 16'hA5A5);
    vecs[22] = mk(0,0,10'h000,16'h0000, 1,0,10'h3FF, 7'b0000001, 10'h3FF, 16'h1234, 16'hA5A5);
    vecs[23] = mk(0,0,10'h000,16'h0000, 1,0,10'h3FF, 7'b0001001, 10'h3FF, 16'h1234, 16'hA5A5);
    vecs[24] = mk(0,0,10'h000,16'h0000, 1,0,10'h3FF, 7'b0000000, 10'h3FF, 16'h1234, 16'hA5A5);
    vecs[25] = mk(0,0,10'h000,16'h0000, 1,0,10'h3FF, 7'b0100101, 10'h3FF, 16'h1234, 16'hA5A5);
    vecs[26] = mk(0,0,10'h000,16'h0000, 1,0,10'h3FF, 7'b0000001, 10'h3FF, 16'h1234, 16'hA5A5);
    vecs[27] = mk(0,0,10'h000,16'h0000, 1,0,10'h3FF, 7'b0001001, 10'h3FF, 16'h1234, 16'hA5A5);
    vecs[28] = mk(0,0,10'h000,16'h0000, 0,0,10'h000, 7'b0000000, 10'h3FF, 16'h1234, 16'hA5A5);

    // Reset state, then 20 idle cycles
    #1 rst = 1'b0;
    #1 chk("reset_outputs",
           {flags_now(), bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_quiet", {57'd0, flags_now()}, 64'd0);
    end

    // Vector table
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk); #1;
      chk($sformatf("flags[%0d]", i), {57'd0, flags_now()}, {57'd0, vecs[i].flags});
      chk($sformatf("addr[%0d]", i),  {54'd0, bus.mem_addr}, {54'd0, vecs[i].addr});
      chk($sformatf("rdata0[%0d]", i), {48'd0, bus.rdata0}, {48'd0, vecs[i].rd0});
      chk($sformatf("rdata1[%0d]", i), {48'd0, bus.rdata1}, {48'd0, vecs[i].rd1});
      if (i == 1) chk("wdata_beef", {48'd0, bus.mem_wdata}, 64'hBEEF);
    end

    // Request raised and dropped between edges: never seen
    @(negedge clk);
    #1 bus.req1 = 1'b1;
    #2 bus.req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("withdrawn", {57'd0, flags_now()}, 64'd0);
    end

    // Async reset during a port 0 write access
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 10'h020; bus.wdata0 = 16'h1111;
    @(posedge clk); #1;
    chk("abort_access", {57'd0, flags_now()}, {57'd0, 7'b1000111});
    #1 rst = 1'b0;
    #1 chk("abort_async_drop", {57'd0, flags_now()}, 64'd0);
    @(negedge clk);
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {57'd0, flags_now()}, 64'd0);
    end
    chk("abort_no_write", {48'd0, ram_read(10'h020)}, 64'd0);
    chk("abort_rdata_clr", {32'd0, bus.rdata0, bus.rdata1}, 64'd0);

    // Tie after reset goes to port 0 again
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 10'h010;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 10'h3FF;
    @(posedge clk); #1;
    chk("tie_after_reset", {57'd0, flags_now()}, {57'd0, 7'b1000101});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("tie_done0", {57'd0, flags_now()}, {57'd0, 7'b0010001});
    chk("tie_rdata0", {48'd0, bus.rdata0}, 64'h1234);
    @(negedge clk);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
